clkgen_multi: RTL and testbench
===============================

# clkgen_multi

Multi-channel, parametrised successor to the DCI baud clock generator. From the divided system clock (nominally 11.7965 MHz / 24 ≈ 491.52 kHz), each of CHANNELS independent channels produces a divided-down baud clock and a one-cycle period-start strobe. The four rates per channel are selected at run time from parameterised divisors. Rate changes are glitch-free, and a channel can be phase-resynchronised (for example, on a receive start bit). It sits between the DCI clock divider and the serial shifters.

## Interface
Parameters:
- CHANNELS, 2: number of independent channels (≥1)
- DIV_W, 12: counter/divisor width in bits
- DIV0, 1632: divisor for rate code 0 (≈301.2 Hz)
- DIV1, 832: divisor for rate code 1 (≈590.8 Hz)
- DIV2, 416: divisor for rate code 2 (≈1181.5 Hz)
- DIV3, 208: divisor for rate code 3 (≈2363 Hz, new mode)
- Constraint: every DIVn must satisfy 2 ≤ DIVn < 2^DIV_W; elaboration fails otherwise.

Ports (one clock; reset is asynchronous and active-high):
- clk_in, input, 1: divided system clock; all logic on rising edge
- rst, input, 1: asynchronous, active-high reset
- en_n, input, CHANNELS: per-channel enable, active-low
- rate_sel, input, 2*CHANNELS: channel i rate code in bits [2i+1:2i]
- resync, input, CHANNELS: per-channel phase restart, active-high, sampled each cycle
- clk_out, output, CHANNELS: per-channel baud clock, registered
- tick, output, CHANNELS: one-cycle strobe on each clk_out period start, registered
- rate_cur, output, 2*CHANNELS: rate code currently in effect per channel, registered

## Operation
Each channel holds the following state: run (1 bit), cnt (DIV_W bits), and div_code (2 bits, mirrored on rate_cur). The divisor in effect is D = DIV[div_code].

Next state, evaluated per channel on every rising edge, highest priority first:
1. **Disabled** (en_n = 1): run=0, cnt=0, div_code unchanged. Outputs clk_out=0 and tick=0.
2. **Start or resync** (run=0, or resync=1): run=1, cnt=0, div_code=rate_sel.
3. **Wrap** (cnt = D−1): cnt=0, div_code=rate_sel. This is the only point where a running channel picks up a new rate.
4. **Otherwise:** cnt=cnt+1.

Outputs are registered from the next state:
- clk_out = (cnt_next < D_next/2). The divide by 2 is an integer floor division.
- tick = run_next AND (cnt_next = 0).

Resulting waveform:
- Period is exactly D cycles. clk_out is high for floor(D/2) cycles and low for the remaining D − floor(D/2) cycles.
- tick coincides with the first high cycle of each period.

Boundary conditions:
- **rate_sel changes mid-period:** ignored until the wrap. The current period completes at the old D, so no runt pulses occur.
- **resync mid-period:** the current period is truncated. The next cycle starts a fresh period (clk_out=1, tick=1) at the currently selected rate. A truncated low phase can be as short as one cycle.
- **resync and wrap in the same cycle:** the result is identical to a wrap; one tick is produced.
- **resync held high:** the channel restarts every cycle, so clk_out=1 and tick=1 continuously.
- **resync while disabled:** ignored.
- **Enable dropped mid-period:** clk_out and tick go to 0 on the next edge. There is no completion of the period.
- **Channel independence:** channels share only clk_in and rst, with no cross-channel interaction.
- **cnt range:** cnt never exceeds D−1, so there is no overflow path.

## Timing
Reset values:
- Every output, every channel: clk_out=0, tick=0, rate_cur=0.
- Internal state: run=0, cnt=0.
- Reset asserts asynchronously; release is sampled on the next rising edge.

Latencies:
- **Enable:** en_n sampled low on edge N gives clk_out=1, tick=1, and rate_cur=rate_sel after edge N. The first full period ends after edge N+D−1.
- **Disable:** en_n sampled high on edge N gives clk_out=0 and tick=0 after edge N.
- **Resync:** resync sampled on edge N gives a period start (tick=1) after edge N.
- **Rate change:** takes effect at the first wrap after rate_sel changes, i.e. within D_old cycles. rate_cur updates on that same edge.

## Test plan
- **Reset, single rate:** rst pulse, then en_n[0]=0 with rate_sel[1:0]=2. clk_out[0] has a 416-cycle period (208 high, 208 low). tick[0] is high exactly 1 cycle per 416. rate_cur[1:0]=2. clk_out and tick are 0 during reset.
- **All rates:** for codes 0–3, measure the period and high time. Required: 1632/816, 832/416, 416/208, 208/104 cycles. At a 2034502 ps clk_in period, 416 cycles ≈ 846.35 µs.
- **Glitch-free change:** channel 0 is at code 0. Switch to code 3 at cnt≈500. The current period completes at 1632 cycles, then 208-cycle periods follow. rate_cur switches on the wrap edge. No high or low phase is shorter than 104 cycles.
- **Resync:** channel 1 at code 2. Pulse resync[1] for 1 cycle at cnt=300. The next cycle gives clk_out=1 and tick=1, and a 416-cycle period follows. Also pulse resync at cnt=415: exactly one tick results, with no double strobe.
- **Disable and independence:** drop en_n[0] mid-high-phase. clk_out[0]=0 on the next cycle. clk_out[1] is unaffected and keeps its cadence. Re-enable: tick on the first cycle.
- **Asynchronous reset mid-operation:** assert rst between edges. All outputs are 0 immediately. After release, enabled channels restart with tick on the first sampled edge.

Source files
------------

// File: rtl/clkgen_multi.sv
// Multi-channel baud clock generator: each channel divides clk_in by one of
// four run-time selectable divisors and emits a baud clock plus a period-start tick.
module clkgen_multi #(
    parameter int CHANNELS = 2,
    parameter int DIV_W    = 12,
    parameter int DIV0     = 1632,
    parameter int DIV1     = 832,
    parameter int DIV2     = 416,
    parameter int DIV3     = 208
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic [CHANNELS-1:0]   en_n,
    input  logic [2*CHANNELS-1:0] rate_sel,
    input  logic [CHANNELS-1:0]   resync,
    output logic [CHANNELS-1:0]   clk_out,
    output logic [CHANNELS-1:0]   tick,
    output logic [2*CHANNELS-1:0] rate_cur
);

    localparam logic [DIV_W-1:0] D0 = DIV_W'(DIV0);
    localparam logic [DIV_W-1:0] D1 = DIV_W'(DIV1);
    localparam logic [DIV_W-1:0] D2 = DIV_W'(DIV2);
    localparam logic [DIV_W-1:0] D3 = DIV_W'(DIV3);

    // Divisors must fit the counter and be at least 2 so both phases exist.
    if (CHANNELS < 1 ||
        DIV0 < 2 || DIV0 >= (1 << DIV_W) ||
        DIV1 < 2 || DIV1 >= (1 << DIV_W) ||
        DIV2 < 2 || DIV2 >= (1 << DIV_W) ||
        DIV3 < 2 || DIV3 >= (1 << DIV_W)) begin : g_bad_param
        $error("clkgen_multi: illegal CHANNELS or divisor parameter");
    end

    function automatic logic [DIV_W-1:0] div_of(input logic [1:0] code);
        logic [DIV_W-1:0] d;
        case (code)
            2'd0:    d = D0;
            2'd1:    d = D1;
            2'd2:    d = D2;
            default: d = D3;
        endcase
        return d;
    endfunction

    function automatic logic [DIV_W-1:0] half_of(input logic [DIV_W-1:0] d);
        return d >> 1;
    endfunction

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic             run_q, run_d;
        logic [DIV_W-1:0] cnt_q, cnt_d;
        logic [1:0]       code_q, code_d;
        logic             clk_q, clk_d;
        logic             tick_q, tick_d;
        logic [DIV_W-1:0] div_cur;
        logic [DIV_W-1:0] div_nxt;
        logic [1:0]       sel;

        always_comb begin
            run_d   = run_q;
            cnt_d   = cnt_q;
            code_d  = code_q;
            sel     = rate_sel[2*i +: 2];
            div_cur = div_of(code_q);

            if (en_n[i]) begin
                run_d = 1'b0;
                cnt_d = '0;
            end else if (!run_q || resync[i]) begin
                run_d  = 1'b1;
                cnt_d  = '0;
                code_d = sel;
            end else if (cnt_q == div_cur - DIV_W'(1)) begin
                // Wrap is the only place a running channel adopts a new rate.
                cnt_d  = '0;
                code_d = sel;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end

            div_nxt = div_of(code_d);
            clk_d   = run_d && (cnt_d < half_of(div_nxt));
            tick_d  = run_d && (cnt_d == '0);
        end

        always_ff @(posedge clk_in or posedge rst) begin
            if (rst) begin
                run_q  <= 1'b0;
                cnt_q  <= '0;
                code_q <= 2'd0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                run_q  <= run_d;
                cnt_q  <= cnt_d;
                code_q <= code_d;
                clk_q  <= clk_d;
                tick_q <= tick_d;
            end
        end

        assign clk_out[i]          = clk_q;
        assign tick[i]             = tick_q;
        assign rate_cur[2*i +: 2]  = code_q;
    end

endmodule

// File: tb/tb_clkgen_multi.sv
// Scoreboard bench for clkgen_multi: per-cycle expected outputs from a behavioural
// model plus period/high-time measurements against the nominal divisor table.
`timescale 1ns/1ps
module tb_clkgen_multi;

    logic       clk_in = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] en_n = 2'b11;
    logic [3:0] rate_sel = 4'd0;
    logic [1:0] resync = 2'b00;
    logic [1:0] clk_out;
    logic [1:0] tick;
    logic [3:0] rate_cur;

    clkgen_multi dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .en_n     (en_n),
        .rate_sel (rate_sel),
        .resync   (resync),
        .clk_out  (clk_out),
        .tick     (tick),
        .rate_cur (rate_cur)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [1:0] c;
        logic [1:0] t;
        logic [3:0] r;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;

    int DIVT[4] = '{1632, 832, 416, 208};
    int HIT[4]  = '{816, 416, 208, 104};

    bit m_run[2];
    int m_cnt[2];
    int m_code[2];

    int per[2], hi[2], tstart[2], hicnt[2], ntick[2];
    bit have[2];

    bit ph_arm, ph_valid, ph_prev;
    int ph_len, minph;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic model_next();
        for (int ch = 0; ch < 2; ch++) begin
            int d;
            d = DIVT[m_code[ch]];
            if (rst) begin
                m_run[ch] = 0; m_cnt[ch] = 0; m_code[ch] = 0;
            end else if (en_n[ch]) begin
                m_run[ch] = 0; m_cnt[ch] = 0;
            end else if (!m_run[ch] || resync[ch]) begin
                m_run[ch] = 1; m_cnt[ch] = 0; m_code[ch] = int'(rate_sel[2*ch +: 2]);
            end else if (m_cnt[ch] == d - 1) begin
                m_cnt[ch] = 0; m_code[ch] = int'(rate_sel[2*ch +: 2]);
            end else begin
                m_cnt[ch]++;
            end
        end
    endtask

    task automatic track();
        for (int ch = 0; ch < 2; ch++) begin
            if (tick[ch]) begin
                if (have[ch]) begin
                    per[ch] = cyc - tstart[ch];
                    hi[ch]  = hicnt[ch];
                end
                have[ch]   = 1;
                tstart[ch] = cyc;
                hicnt[ch]  = 0;
                ntick[ch]++;
            end
            if (clk_out[ch]) hicnt[ch]++;
        end
        if (ph_arm) begin
            if (clk_out[0] != ph_prev) begin
                if (ph_valid && ph_len < minph) minph = ph_len;
                ph_valid = 1;
                ph_len   = 1;
            end else begin
                ph_len++;
            end
            ph_prev = clk_out[0];
        end
    endtask

    task automatic step();
        exp_t e;
        model_next();
        for (int ch = 0; ch < 2; ch++) begin
            e.c[ch] = m_run[ch] && (m_cnt[ch] < DIVT[m_code[ch]] / 2);
            e.t[ch] = m_run[ch] && (m_cnt[ch] == 0);
            e.r[2*ch +: 2] = 2'(m_code[ch]);
        end
        sb.push_back(e);
        @(posedge clk_in);
        #1;
        cyc++;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("cyc", {24'd0, clk_out, tick, rate_cur}, {24'd0, e.c, e.t, e.r});
        end
        track();
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int ch = 0; ch < 2; ch++) begin
            m_run[ch] = 0; m_cnt[ch] = 0; m_code[ch] = 0;
            per[ch] = 0; hi[ch] = 0; tstart[ch] = 0; hicnt[ch] = 0; ntick[ch] = 0; have[ch] = 0;
        end
        ph_arm = 0; ph_valid = 0; ph_prev = 0; ph_len = 0; minph = 1 << 30;

        // Reset, then single rate on channel 0
        #1 rst = 1'b1;
        #1 check("rst_out", {24'd0, clk_out, tick, rate_cur}, 32'd0);
        steps(3);
        check("rst_hold", {24'd0, clk_out, tick, rate_cur}, 32'd0);
        rst = 1'b0;
        rate_sel[1:0] = 2'd2;
        en_n[0] = 1'b0;
        step();
        check("en_tick", tick[0], 1);
        check("en_clk", clk_out[0], 1);
        check("en_rate", rate_cur[1:0], 2);
        steps(415);
        ntick[0] = 0;
        steps(832);
        check("t1_ticks", ntick[0], 2);
        check("t1_per", per[0], 416);
        check("t1_hi", hi[0], 208);

        // All rates on channel 1
        for (int code = 0; code < 4; code++) begin
            en_n[1] = 1'b1;
            step();
            have[1] = 0;
            rate_sel[3:2] = 2'(code);
            en_n[1] = 1'b0;
            steps(3 * DIVT[code]);
            check($sformatf("per_c%0d", code), per[1], DIVT[code]);
            check($sformatf("hi_c%0d", code), hi[1], HIT[code]);
            check($sformatf("rate_c%0d", code), rate_cur[3:2], code);
        end

        // Glitch-free change on channel 0: code 0 -> 3 at cnt 500
        en_n[0] = 1'b1;
        step();
        have[0] = 0;
        rate_sel[1:0] = 2'd0;
        en_n[0] = 1'b0;
        step();
        steps(500);
        ph_arm = 1; ph_valid = 0; ph_prev = clk_out[0]; ph_len = 0; minph = 1 << 30;
        rate_sel[1:0] = 2'd3;
        n = 0;
        for (int k = 1; k <= 2000; k++) begin
            step();
            if (rate_cur[1:0] == 2'd3) begin
                n = k;
                break;
            end
        end
        check("wrap_cyc", n, 1132);
        check("wrap_tick", tick[0], 1);
        check("old_per", per[0], 1632);
        check("old_hi", hi[0], 816);
        steps(3 * 208);
        check("new_per", per[0], 208);
        check("new_hi", hi[0], 104);
        check("min_phase", minph, 104);
        ph_arm = 0;

        // Resync on channel 1 at code 2
        en_n[1] = 1'b1;
        step();
        have[1] = 0;
        rate_sel[3:2] = 2'd2;
        en_n[1] = 1'b0;
        step();
        steps(300);
        resync[1] = 1'b1;
        step();
        resync[1] = 1'b0;
        check("rs_tick", tick[1], 1);
        check("rs_clk", clk_out[1], 1);
        check("rs_trunc", per[1], 301);
        steps(420);
        check("rs_per", per[1], 416);
        steps(411);
        ntick[1] = 0;
        resync[1] = 1'b1;
        step();
        resync[1] = 1'b0;
        steps(3);
        check("rs_wrap_ticks", ntick[1], 1);

        // Disable channel 0 mid-high, channel 1 keeps cadence
        for (int k = 0; k < 300; k++) begin
            if (clk_out[0] && !tick[0]) break;
            step();
        end
        check("dis_pre_hi", clk_out[0], 1);
        en_n[0] = 1'b1;
        step();
        check("dis_clk", clk_out[0], 0);
        check("dis_tick", tick[0], 0);
        resync[0] = 1'b1;
        step();
        resync[0] = 1'b0;
        check("dis_rs_clk", clk_out[0], 0);
        steps(840);
        check("indep_per", per[1], 416);
        check("indep_hi", hi[1], 208);
        en_n[0] = 1'b0;
        step();
        check("reen_tick", tick[0], 1);
        check("reen_clk", clk_out[0], 1);
        steps(50);

        // Asynchronous reset between edges
        #5 rst = 1'b1;
        #1;
        check("arst_clk", clk_out, 0);
        check("arst_tick", tick, 0);
        check("arst_rate", rate_cur, 0);
        for (int ch = 0; ch < 2; ch++) begin
            m_run[ch] = 0; m_cnt[ch] = 0; m_code[ch] = 0;
        end
        steps(2);
        rst = 1'b0;
        step();
        check("arst_restart", tick, 2'b11);
        check("arst_rate_new", rate_cur, {2'd2, 2'd3});
        steps(20);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
